exer_vram_arbiter: RTL and testbench
====================================

# exer_vram_arbiter

Single-port access arbiter that shares one 2K×8 synchronous video RAM (cen-gated, one-cycle registered read) between the main CPU and the video fetch pipeline. Video fetches have priority. A programmable starvation limit guarantees the CPU a slot. The CPU gets a request/acknowledge handshake with wait semantics. The block sits between the CPU bus decoder, the tile/sprite fetch logic and the RAM instance.

## Interface
Parameters:
- AW, 11, address width
- DW, 8, data width
- STARVE_MAX, 4, consecutive video grants allowed while a CPU request is pending; 0 = video absolute priority

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, held until ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high
- cpu_addr  in  AW  CPU address
- cpu_din  in  DW  CPU write data
- cpu_dout  out  DW  CPU read data
- cpu_ack  out  1  one-cycle completion pulse
- vid_req  in  1  video fetch request, may be asserted every cycle
- vid_addr  in  AW  video fetch address
- vid_gnt  out  1  combinational: video fetch issued this cycle
- vid_dout  out  DW  video read data
- vid_valid  out  1  vid_dout valid (cycle after vid_gnt)
- ram_cen  out  1  RAM cycle enable
- ram_nwe  out  1  RAM write enable, active low
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_q  in  DW  RAM registered read data

## Operation
- Issue stage (combinational): winner chosen each cycle; winner drives ram_addr and ram_cen=1. For CPU writes it also drives ram_nwe=0 and ram_din=cpu_din. With no winner: ram_cen=0, ram_nwe=1, ram_addr/ram_din hold last value.
- CPU eligible only when CPU FSM is C_IDLE and cpu_req=1.
- Priority: video wins if vid_req=1, unless starve_cnt == STARVE_MAX and STARVE_MAX != 0, in which case CPU wins.
- starve_cnt: +1 when video wins while CPU is eligible. Cleared when CPU is granted or CPU is not eligible. Saturates at STARVE_MAX. Width clog2(STARVE_MAX+1), minimum 1.
- CPU FSM:
  - C_IDLE → C_DATA on CPU grant.
  - C_DATA: cpu_ack=1. Next state is C_HOLD if cpu_req=1, else C_IDLE.
  - C_HOLD → C_IDLE when cpu_req=0.
  - The C_HOLD state blocks double issue while the CPU still holds req.
- cpu_dout:
  - In C_DATA with a read: cpu_dout=ram_q, and the held register loads ram_q.
  - Otherwise: held register value.
  - A write ack leaves the held value unchanged.
- vid_valid is a registered copy of vid_gnt. vid_dout=ram_q (pass-through).
- Reset values: cpu_ack=0, cpu_dout=0, vid_valid=0, vid_gnt=0, ram_cen=0, ram_nwe=1, ram_addr=0, ram_din=0. FSM=C_IDLE, starve_cnt=0.

## Timing
- Grant at cycle N. RAM samples at the edge ending N. cpu_ack / vid_valid and data are valid in cycle N+1.
- Back-to-back video: one fetch per cycle, full throughput.
- CPU throughput: at most one access per 2 cycles (C_DATA then C_IDLE). Ack-to-next-grant latency is ≥1 cycle.
- Worst-case CPU wait under continuous video: STARVE_MAX cycles before grant.
- CPU and video requesting in the same cycle with counter below the limit: video wins, CPU waits. No lost requests.
- Reset mid-access: pending ack is discarded and never asserted. A write already sampled by the RAM stands. After release, if cpu_req is still high, the access is re-issued from C_IDLE.
- No combinational path from ram_q to any grant or enable signal.

## Structure
- Shared package exer_vram_pkg holds:
  - CPU FSM state enum (C_IDLE, C_DATA, C_HOLD)
  - default AW/DW constants
  - a clog2-style width constant function for the counter
- One natural sub-module, exer_starve_cnt: saturating counter with clear/inc/at_limit outputs, parameterised by STARVE_MAX. Everything else stays in the top module.

## Test plan
- CPU read alone: RAM[0x123]=0x5A, cpu_req read 0x123 at cycle 0 → ram_cen=1 cycle 0; cpu_ack=1 and cpu_dout=0x5A cycle 1; cpu_dout stays 0x5A afterwards.
- CPU write with req held: write 0x7FF=0xA5, cpu_req high 4 cycles → exactly one ram_nwe=0 pulse (cycle 0), one cpu_ack (cycle 1), no CPU ram_cen in cycles 2-3; later read of 0x7FF returns 0xA5.
- Video streaming: vid_req every cycle, vid_addr 0x000..0x00F, RAM[i]=i → vid_valid cycles 1-16, vid_dout=0x00..0x0F in order.
- Starvation, STARVE_MAX=4: continuous vid_req, cpu_req read raised at cycle 0 → vid_gnt=1 cycles 0-3, CPU granted cycle 4 (vid_gnt=0), cpu_ack cycle 5, vid_valid=0 cycle 5, video resumes cycle 5.
- STARVE_MAX=0: continuous vid_req for 100 cycles with cpu_req high → no cpu_ack; drop vid_req at cycle 100 → CPU granted cycle 100, ack cycle 101.
- Reset in C_DATA: CPU read granted cycle 0, reset asserted cycle 1 → cpu_ack=0, all outputs at reset values; release with cpu_req still high → fresh grant and ack two cycles later with correct data.

Source files
------------

// File: rtl/exer_vram_pkg.sv
// Shared types and constants for the video RAM arbiter: CPU FSM states,
// default bus widths and the starvation counter width helper.
package exer_vram_pkg;

    localparam int AW_DEF = 11;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_DATA = 2'd1,
        C_HOLD = 2'd2
    } cpu_state_t;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) < (max_val + 1)) w++;
        return w;
    endfunction

endpackage

// File: rtl/exer_starve_cnt.sv
// Saturating count of video grants taken while the CPU waits; at_limit
// hands the next slot to the CPU.
module exer_starve_cnt
    import exer_vram_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam int W = cnt_width(STARVE_MAX);
    localparam logic [W-1:0] LIMIT = W'(STARVE_MAX);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIMIT)) begin
            cnt <= cnt + W'(1);
        end
    end

    // A limit of zero means video never yields.
    assign at_limit = (STARVE_MAX != 0) && (cnt == LIMIT);

endmodule

// File: rtl/exer_vram_arbiter.sv
// Shares one single-port synchronous video RAM between the CPU bus and the
// video fetch pipeline; video has priority, bounded by a starvation limit.
//
// state  | meaning
// C_IDLE | no CPU access in flight, CPU may be granted
// C_DATA | RAM sampled the CPU access last cycle, ack (and read data) now
// C_HOLD | access done, waiting for CPU to drop req
module exer_vram_arbiter
    import exer_vram_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_ack,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_gnt,
    output logic [DW-1:0] vid_dout,
    output logic          vid_valid,
    output logic          ram_cen,
    output logic          ram_nwe,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_q
);

    cpu_state_t    state, state_nx;
    logic          cpu_elig, cpu_win, vid_win, at_limit, we_q;
    logic [DW-1:0] dout_q, din_q;
    logic [AW-1:0] addr_q;

    // Issue is suppressed while reset is high so the RAM sees no cycle.
    assign cpu_elig = !reset && (state == C_IDLE) && cpu_req;
    assign cpu_win  = cpu_elig && (!vid_req || at_limit);
    assign vid_win  = !reset && vid_req && !cpu_win;

    assign vid_gnt  = vid_win;
    assign ram_cen  = cpu_win || vid_win;
    assign ram_nwe  = !(cpu_win && cpu_we);
    assign ram_addr = cpu_win ? cpu_addr : (vid_win ? vid_addr : addr_q);
    assign ram_din  = (cpu_win && cpu_we) ? cpu_din : din_q;
    assign vid_dout = ram_q;
    assign cpu_dout = ((state == C_DATA) && !we_q) ? ram_q : dout_q;

    exer_starve_cnt #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .clr     (!cpu_elig || cpu_win),
        .inc     (vid_win && cpu_elig),
        .at_limit(at_limit)
    );

    always_comb begin
        state_nx = state;
        cpu_ack  = 1'b0;
        case (state)
            C_IDLE: if (cpu_win) state_nx = C_DATA;
            C_DATA: begin
                cpu_ack  = 1'b1;
                state_nx = cpu_req ? C_HOLD : C_IDLE;
            end
            C_HOLD: if (!cpu_req) state_nx = C_IDLE;
            default: state_nx = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= C_IDLE;
            we_q      <= 1'b0;
            dout_q    <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            vid_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            vid_valid <= vid_win;
            addr_q    <= ram_addr;
            din_q     <= ram_din;
            if (cpu_win) we_q <= cpu_we;
            if ((state == C_DATA) && !we_q) dout_q <= ram_q;
        end
    end

endmodule

// File: tb/tb_exer_vram_arbiter.sv
// Directed bench: two arbiters (STARVE_MAX=4 and 0) share stimulus, each
// with its own behavioural 2Kx8 synchronous RAM.
module tb_exer_vram_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, vid_req;
    logic [10:0] cpu_addr, vid_addr;
    logic [7:0]  cpu_din;

    logic [7:0]  cpu_dout, vid_dout, ram_din, ram_q;
    logic        cpu_ack, vid_gnt, vid_valid, ram_cen, ram_nwe;
    logic [10:0] ram_addr;

    logic [7:0]  cpu_dout0, vid_dout0, ram_din0, ram_q0;
    logic        cpu_ack0, vid_gnt0, vid_valid0, ram_cen0, ram_nwe0;
    logic [10:0] ram_addr0;

    logic [7:0]  mem_a [0:2047];
    logic [7:0]  mem_b [0:2047];

    int checks = 0;
    int failures = 0;

    exer_vram_arbiter #(.AW(11), .DW(8), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_dout(vid_dout), .vid_valid(vid_valid),
        .ram_cen(ram_cen), .ram_nwe(ram_nwe), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_q(ram_q)
    );

    exer_vram_arbiter #(.AW(11), .DW(8), .STARVE_MAX(0)) dut0 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout0), .cpu_ack(cpu_ack0),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt0),
        .vid_dout(vid_dout0), .vid_valid(vid_valid0),
        .ram_cen(ram_cen0), .ram_nwe(ram_nwe0), .ram_addr(ram_addr0),
        .ram_din(ram_din0), .ram_q(ram_q0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_cen) begin
            if (!ram_nwe) mem_a[ram_addr] <= ram_din;
            else          ram_q <= mem_a[ram_addr];
        end
    end

    always @(posedge clk) begin
        if (ram_cen0) begin
            if (!ram_nwe0) mem_b[ram_addr0] <= ram_din0;
            else           ram_q0 <= mem_b[ram_addr0];
        end
    end

    task automatic test_reset();
        reset = 1'b1; cpu_req = 1'b1; vid_req = 1'b1;
        cpu_addr = 11'h123; vid_addr = 11'h004;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (cpu_ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%0h exp=0", cpu_ack); end
        checks++; if (cpu_dout !== 8'h00) begin failures++; $display("FAIL rst_dout got=%0h exp=0", cpu_dout); end
        checks++; if (vid_valid !== 1'b0) begin failures++; $display("FAIL rst_vvalid got=%0h exp=0", vid_valid); end
        checks++; if (vid_gnt !== 1'b0) begin failures++; $display("FAIL rst_vgnt got=%0h exp=0", vid_gnt); end
        checks++; if (ram_cen !== 1'b0) begin failures++; $display("FAIL rst_cen got=%0h exp=0", ram_cen); end
        checks++; if (ram_nwe !== 1'b1) begin failures++; $display("FAIL rst_nwe got=%0h exp=1", ram_nwe); end
        checks++; if (ram_addr !== 11'h000) begin failures++; $display("FAIL rst_addr got=%0h exp=0", ram_addr); end
        checks++; if (ram_din !== 8'h00) begin failures++; $display("FAIL rst_din got=%0h exp=0", ram_din); end
        checks++; if (ram_cen0 !== 1'b0) begin failures++; $display("FAIL rst_cen0 got=%0h exp=0", ram_cen0); end
        @(posedge clk); #1;
        cpu_req = 1'b0; vid_req = 1'b0; reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h123;
        @(negedge clk);
        checks++; if (ram_cen !== 1'b1) begin failures++; $display("FAIL rd_cen got=%0h exp=1", ram_cen); end
        checks++; if (ram_nwe !== 1'b1) begin failures++; $display("FAIL rd_nwe got=%0h exp=1", ram_nwe); end
        checks++; if (ram_addr !== 11'h123) begin failures++; $display("FAIL rd_addr got=%0h exp=123", ram_addr); end
        checks++; if (cpu_ack !== 1'b0) begin failures++; $display("FAIL rd_ack0 got=%0h exp=0", cpu_ack); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (cpu_ack !== 1'b1) begin failures++; $display("FAIL rd_ack1 got=%0h exp=1", cpu_ack); end
        checks++; if (cpu_dout !== 8'h5A) begin failures++; $display("FAIL rd_dout1 got=%0h exp=5a", cpu_dout); end
        checks++; if (ram_cen !== 1'b0) begin failures++; $display("FAIL rd_cen1 got=%0h exp=0", ram_cen); end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        for (int c = 2; c < 4; c++) begin
            @(negedge clk);
            checks++; if (cpu_ack !== 1'b0) begin failures++; $display("FAIL rd_ack_c%0d got=%0h exp=0", c, cpu_ack); end
            checks++; if (cpu_dout !== 8'h5A) begin failures++; $display("FAIL rd_hold_c%0d got=%0h exp=5a", c, cpu_dout); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_cpu_write();
        int nwe_cnt, nwe_cyc, ack_cnt, ack_cyc, late_cen;
        nwe_cnt = 0; nwe_cyc = -1; ack_cnt = 0; ack_cyc = -1; late_cen = 0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h7FF; cpu_din = 8'hA5;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (!ram_nwe) begin nwe_cnt++; nwe_cyc = c; end
            if (cpu_ack) begin ack_cnt++; ack_cyc = c; end
            if (c >= 2 && ram_cen) late_cen++;
            if (c == 0) begin
                checks++; if (ram_din !== 8'hA5) begin failures++; $display("FAIL wr_din got=%0h exp=a5", ram_din); end
            end
            if (c == 1) begin
                checks++; if (cpu_dout !== 8'h5A) begin failures++; $display("FAIL wr_dout_keep got=%0h exp=5a", cpu_dout); end
            end
            @(posedge clk); #1;
        end
        checks++; if (nwe_cnt !== 1 || nwe_cyc !== 0) begin failures++; $display("FAIL wr_nwe got=%0d@%0d exp=1@0", nwe_cnt, nwe_cyc); end
        checks++; if (ack_cnt !== 1 || ack_cyc !== 1) begin failures++; $display("FAIL wr_ack got=%0d@%0d exp=1@1", ack_cnt, ack_cyc); end
        checks++; if (late_cen !== 0) begin failures++; $display("FAIL wr_late_cen got=%0d exp=0", late_cen); end
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        checks++; if (ram_cen !== 1'b0) begin failures++; $display("FAIL wr_hold_cen got=%0h exp=0", ram_cen); end
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_addr = 11'h7FF;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (cpu_ack !== 1'b1) begin failures++; $display("FAIL wr_rb_ack got=%0h exp=1", cpu_ack); end
        checks++; if (cpu_dout !== 8'hA5) begin failures++; $display("FAIL wr_rb_dout got=%0h exp=a5", cpu_dout); end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_video_stream();
        for (int k = 0; k <= 16; k++) begin
            vid_req = (k < 16);
            vid_addr = 11'(k);
            @(negedge clk);
            if (k < 16) begin
                checks++; if (vid_gnt !== 1'b1) begin failures++; $display("FAIL vs_gnt_%0d got=%0h exp=1", k, vid_gnt); end
            end
            if (k >= 1) begin
                checks++; if (vid_valid !== 1'b1) begin failures++; $display("FAIL vs_valid_%0d got=%0h exp=1", k, vid_valid); end
                checks++; if (vid_dout !== 8'(k - 1)) begin failures++; $display("FAIL vs_dout_%0d got=%0h exp=%0h", k, vid_dout, 8'(k - 1)); end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (vid_valid !== 1'b0) begin failures++; $display("FAIL vs_valid_end got=%0h exp=0", vid_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_starvation();
        vid_req = 1'b1; vid_addr = 11'h00F;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h123;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 4) begin
                checks++; if (vid_gnt !== 1'b1) begin failures++; $display("FAIL st_gnt_%0d got=%0h exp=1", c, vid_gnt); end
            end
            if (c < 5) begin
                checks++; if (cpu_ack !== 1'b0) begin failures++; $display("FAIL st_ack_%0d got=%0h exp=0", c, cpu_ack); end
            end
            if (c == 4) begin
                checks++; if (vid_gnt !== 1'b0) begin failures++; $display("FAIL st_gnt4 got=%0h exp=0", vid_gnt); end
                checks++; if (ram_addr !== 11'h123) begin failures++; $display("FAIL st_addr4 got=%0h exp=123", ram_addr); end
            end
            if (c == 5) begin
                checks++; if (cpu_ack !== 1'b1) begin failures++; $display("FAIL st_ack5 got=%0h exp=1", cpu_ack); end
                checks++; if (cpu_dout !== 8'h5A) begin failures++; $display("FAIL st_dout5 got=%0h exp=5a", cpu_dout); end
                checks++; if (vid_valid !== 1'b0) begin failures++; $display("FAIL st_valid5 got=%0h exp=0", vid_valid); end
                checks++; if (vid_gnt !== 1'b1) begin failures++; $display("FAIL st_gnt5 got=%0h exp=1", vid_gnt); end
            end
            @(posedge clk); #1;
        end
        cpu_req = 1'b0;
        @(negedge clk);
        checks++; if (vid_valid !== 1'b1) begin failures++; $display("FAIL st_valid6 got=%0h exp=1", vid_valid); end
        @(posedge clk); #1;
        vid_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_no_starve();
        int acks0;
        acks0 = 0;
        vid_req = 1'b1; vid_addr = 11'h000;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h123;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (cpu_ack0) acks0++;
            @(posedge clk); #1;
        end
        checks++; if (acks0 !== 0) begin failures++; $display("FAIL ns_acks got=%0d exp=0", acks0); end
        vid_req = 1'b0;
        @(negedge clk);
        checks++; if (ram_cen0 !== 1'b1 || ram_addr0 !== 11'h123) begin failures++; $display("FAIL ns_grant got=cen%0h/%0h exp=cen1/123", ram_cen0, ram_addr0); end
        checks++; if (vid_gnt0 !== 1'b0) begin failures++; $display("FAIL ns_vgnt got=%0h exp=0", vid_gnt0); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (cpu_ack0 !== 1'b1) begin failures++; $display("FAIL ns_ack got=%0h exp=1", cpu_ack0); end
        checks++; if (cpu_dout0 !== 8'h5A) begin failures++; $display("FAIL ns_dout got=%0h exp=5a", cpu_dout0); end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h00A; vid_req = 1'b0;
        @(negedge clk);
        checks++; if (ram_cen !== 1'b1) begin failures++; $display("FAIL rm_cen0 got=%0h exp=1", ram_cen); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (cpu_ack !== 1'b0) begin failures++; $display("FAIL rm_ack got=%0h exp=0", cpu_ack); end
        checks++; if (cpu_dout !== 8'h00) begin failures++; $display("FAIL rm_dout got=%0h exp=0", cpu_dout); end
        checks++; if (ram_cen !== 1'b0 || ram_nwe !== 1'b1) begin failures++; $display("FAIL rm_ctl got=cen%0h/nwe%0h exp=cen0/nwe1", ram_cen, ram_nwe); end
        checks++; if (ram_addr !== 11'h000 || ram_din !== 8'h00) begin failures++; $display("FAIL rm_bus got=%0h/%0h exp=0/0", ram_addr, ram_din); end
        checks++; if (vid_valid !== 1'b0 || vid_gnt !== 1'b0) begin failures++; $display("FAIL rm_vid got=%0h/%0h exp=0/0", vid_valid, vid_gnt); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (ram_cen !== 1'b1 || ram_addr !== 11'h00A) begin failures++; $display("FAIL rm_regrant got=cen%0h/%0h exp=cen1/00a", ram_cen, ram_addr); end
        checks++; if (cpu_ack !== 1'b0) begin failures++; $display("FAIL rm_ack2 got=%0h exp=0", cpu_ack); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (cpu_ack !== 1'b1) begin failures++; $display("FAIL rm_ack3 got=%0h exp=1", cpu_ack); end
        checks++; if (cpu_dout !== 8'h0A) begin failures++; $display("FAIL rm_dout3 got=%0h exp=0a", cpu_dout); end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; vid_req = 1'b0;
        cpu_addr = '0; vid_addr = '0; cpu_din = '0;
        for (int i = 0; i < 2048; i++) begin
            mem_a[i] <= 8'h00;
            mem_b[i] <= 8'h00;
        end
        for (int i = 0; i < 16; i++) begin
            mem_a[i] <= 8'(i);
            mem_b[i] <= 8'(i);
        end
        mem_a[11'h123] <= 8'h5A;
        mem_b[11'h123] <= 8'h5A;
        ram_q <= 8'h00;
        ram_q0 <= 8'h00;

        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_video_stream();
        test_starvation();
        test_no_starve();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
